fetch_decode: RTL and testbench
===============================

FETCH_DECODE -- requirements
Module: fetch_decode

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk input 1, rising-edge clock; rst input 1, asynchronous active-low reset.
REQ-002 imem_addr output 10: instruction word address, equal to pc.
REQ-003 imem_rden output 1: instruction read strobe.
REQ-004 imem_rdata input 32: instruction word, valid the cycle after imem_rden (registered read).
REQ-005 op_valid output 1: decoded instruction held on outputs.
REQ-006 op_ready input 1: control unit accepts the decoded instruction.
REQ-007 op_code output 6: instruction index in the control-unit encoding (LUI=0 ... AND=36, ECALL=37); 63 means illegal.
REQ-008 op_rd, op_rs1, op_rs2 output 5 each: register fields [11:7], [19:15], [24:20].
REQ-009 op_imm output 32: decoded immediate.
REQ-010 op_pc output 10: word address of the held instruction.
REQ-011 pc_wren input 1: redirect request.
REQ-012 pc_add_or_set input 1: redirect mode, 1 = set, 0 = add.
REQ-013 pc_value input 10: redirect target when setting, or word offset when adding.

Function
REQ-014 The FSM SHALL have three states: REQ, WAIT, HOLD.
REQ-015 REQ: imem_rden=1 and imem_addr=pc; next state WAIT.
REQ-016 WAIT: imem_rdata is decoded and all op_* outputs are registered at the end of the cycle; op_pc<=pc and op_valid<=1; next state HOLD.
REQ-017 HOLD: op_valid=1 and all op_* outputs stay stable. When op_ready=1: op_valid<=0, pc<=pc+1, next state REQ.
REQ-018 Latency: op_valid SHALL rise on the 2nd clock edge after entering REQ; peak throughput is one instruction per 3 cycles.
REQ-019 pc arithmetic SHALL be modulo 1024: pc+1 from 1023 wraps to 0, and add-redirect sums wrap the same way.
REQ-020 A redirect (pc_wren=1) in any state SHALL be handled as follows:
- pc<=pc_value if pc_add_or_set=1, else pc<=op_pc+pc_value;
- op_valid<=0;
- next state REQ;
- redirect has priority over op_ready in the same cycle.
REQ-021 A redirect in WAIT SHALL discard the returning word; no op_valid results from it.
REQ-022 imem_rden SHALL be 0 in WAIT and HOLD.
REQ-023 Decode SHALL use opcode [6:0], funct3 [14:12] and funct7 [31:25], per RV32I.
REQ-024 SLLI and SRLI require funct7=0x00; SRAI requires 0x20; SUB and SRA require 0x20; all other R-type instructions require 0x00.
REQ-025 ECALL SHALL be recognised only on the exact word 0x00000073; every other SYSTEM word, unmatched encoding or reserved funct value yields op_code=63 with op_valid still asserted.
REQ-026 Immediates SHALL be sign-extended from bit 31, by format:
- I: [31:20];
- S: {[31:25],[11:7]};
- B: {[31],[7],[30:25],[11:8],0};
- U: {[31:12],12'b0};
- J: {[31],[19:12],[20],[30:21],0}.
REQ-027 Shift-immediate op_imm SHALL be the zero-extended shamt [24:20]; R-type op_imm SHALL be 0.
REQ-028 op_rd, op_rs1 and op_rs2 SHALL be the raw bit fields regardless of format.

Reset
REQ-029 While rst=0, the block SHALL immediately hold: state REQ, pc=0, op_valid=0, op_code=0, op_rd/op_rs1/op_rs2=0, op_imm=0, op_pc=0, and imem_rden=0.
REQ-030 On the first clock edge after rst releases, the block SHALL issue a fetch from address 0.
REQ-031 Reset asserted mid-operation (WAIT or HOLD) SHALL abandon the instruction; no op_valid follows from it.

Verification
REQ-032 Addi fetch: imem[0]=0x00500093, op_ready=1 -> op_valid on the 2nd edge after the first REQ, with op_code=18, op_rd=1, op_rs1=0, op_imm=5, op_pc=0; next fetch address is 1.
REQ-033 Negative and upper immediates: imem[1]=0xFFF00113 -> op_code=18, op_imm=0xFFFFFFFF; imem[2]=0x12345037 -> op_code=0, op_imm=0x12345000.
REQ-034 Backpressure: op_ready=0 for 5 cycles in HOLD -> all op_* outputs stable, imem_rden=0 throughout; op_ready=1 -> pc advances by 1.
REQ-035 Redirect and wrap: pc_wren=1, pc_add_or_set=1, pc_value=0x3FF during WAIT -> data discarded, next imem_addr=0x3FF; after acceptance the next imem_addr=0x000. Simultaneously, pc_wren=1 (add, pc_value=0x004) with op_ready=1 at op_pc=0x010 -> next imem_addr=0x014.
REQ-036 Illegal and system words: 0xFFFFFFFF -> op_code=63; 0x00000073 -> op_code=37; 0x00100073 -> op_code=63.
REQ-037 Reset in HOLD: rst=0 -> op_valid=0 without waiting for a clock edge; after release, imem_addr=0.

Source files
------------

// File: rtl/fetch_decode.sv
// fetch_decode: three-state instruction fetch (REQ/WAIT/HOLD) with RV32I decode and pc redirect
module fetch_decode (
    input  logic        clk,
    input  logic        rst,
    output logic [9:0]  imem_addr,
    output logic        imem_rden,
    input  logic [31:0] imem_rdata,
    output logic        op_valid,
    input  logic        op_ready,
    output logic [5:0]  op_code,
    output logic [4:0]  op_rd,
    output logic [4:0]  op_rs1,
    output logic [4:0]  op_rs2,
    output logic [31:0] op_imm,
    output logic [9:0]  op_pc,
    input  logic        pc_wren,
    input  logic        pc_add_or_set,
    input  logic [9:0]  pc_value
);
    typedef enum logic [1:0] {REQ, WAIT, HOLD} state_t;

    state_t      state, state_nx;
    logic [9:0]  pc;
    logic [31:0] w;
    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    logic [5:0]  dec_code;
    logic [31:0] dec_imm;

    assign w         = imem_rdata;
    assign opc       = w[6:0];
    assign f3        = w[14:12];
    assign f7        = w[31:25];
    assign imem_addr = pc;
    // the strobe is masked by reset so nothing is fetched while reset is held
    assign imem_rden = rst && (state == REQ);

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= REQ;
        else      state <= state_nx;
    end

    // next state: a redirect always restarts the fetch, overriding acceptance
    always_comb begin
        state_nx = state;
        state_nx = pc_wren ? REQ :
                   (state == REQ)  ? WAIT :
                   (state == WAIT) ? HOLD :
                   op_ready ? REQ : HOLD;
    end

    // RV32I decode of the returning word into control-unit index and immediate
    always_comb begin
        dec_code = 6'd63;
        dec_imm  = {{20{w[31]}}, w[31:20]};
        case (opc)
            7'h37: begin dec_code = 6'd0; dec_imm = {w[31:12], 12'd0}; end
            7'h17: begin dec_code = 6'd1; dec_imm = {w[31:12], 12'd0}; end
            7'h6f: begin
                dec_code = 6'd2;
                dec_imm  = {{12{w[31]}}, w[19:12], w[20], w[30:21], 1'b0};
            end
            7'h67: dec_code = (f3 == 3'd0) ? 6'd3 : 6'd63;
            7'h63: begin
                dec_code = (f3 == 3'd2 || f3 == 3'd3) ? 6'd63 :
                           f3[2] ? 6'd2 + {3'd0, f3} : 6'd4 + {3'd0, f3};
                dec_imm  = {{20{w[31]}}, w[7], w[30:25], w[11:8], 1'b0};
            end
            7'h03: dec_code = (f3 == 3'd3 || f3 >= 3'd6) ? 6'd63 :
                              f3[2] ? 6'd9 + {3'd0, f3} : 6'd10 + {3'd0, f3};
            7'h23: begin
                dec_code = (f3 < 3'd3) ? 6'd15 + {3'd0, f3} : 6'd63;
                dec_imm  = {{20{w[31]}}, w[31:25], w[11:7]};
            end
            7'h13: begin
                case (f3)
                    3'd0: dec_code = 6'd18;
                    3'd2: dec_code = 6'd19;
                    3'd3: dec_code = 6'd20;
                    3'd4: dec_code = 6'd21;
                    3'd6: dec_code = 6'd22;
                    3'd7: dec_code = 6'd23;
                    3'd1: begin
                        dec_code = (f7 == 7'h00) ? 6'd24 : 6'd63;
                        dec_imm  = {27'd0, w[24:20]};
                    end
                    default: begin
                        dec_code = (f7 == 7'h00) ? 6'd25 : (f7 == 7'h20) ? 6'd26 : 6'd63;
                        dec_imm  = {27'd0, w[24:20]};
                    end
                endcase
            end
            7'h33: begin
                dec_imm = 32'd0;
                if (f7 == 7'h00) begin
                    case (f3)
                        3'd0: dec_code = 6'd27;
                        3'd1: dec_code = 6'd29;
                        3'd2: dec_code = 6'd30;
                        3'd3: dec_code = 6'd31;
                        3'd4: dec_code = 6'd32;
                        3'd5: dec_code = 6'd33;
                        3'd6: dec_code = 6'd35;
                        default: dec_code = 6'd36;
                    endcase
                end else if (f7 == 7'h20) begin
                    dec_code = (f3 == 3'd0) ? 6'd28 : (f3 == 3'd5) ? 6'd34 : 6'd63;
                end
            end
            7'h73: dec_code = (w == 32'h0000_0073) ? 6'd37 : 6'd63;
            default: ;
        endcase
    end

    // pc and held instruction: redirect beats capture and acceptance
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc       <= '0;
            op_valid <= 1'b0;
            op_code  <= '0;
            op_rd    <= '0;
            op_rs1   <= '0;
            op_rs2   <= '0;
            op_imm   <= '0;
            op_pc    <= '0;
        end else if (pc_wren) begin
            pc       <= pc_add_or_set ? pc_value : op_pc + pc_value;
            op_valid <= 1'b0;
        end else if (state == WAIT) begin
            op_valid <= 1'b1;
            op_code  <= dec_code;
            op_rd    <= w[11:7];
            op_rs1   <= w[19:15];
            op_rs2   <= w[24:20];
            op_imm   <= dec_imm;
            op_pc    <= pc;
        end else if (state == HOLD && op_ready) begin
            op_valid <= 1'b0;
            pc       <= pc + 10'd1;
        end
    end
endmodule

// File: tb/tb_fetch_decode.sv
// tb_fetch_decode: directed and randomized checks of fetch_decode against a table-driven RV32I model
module tb_fetch_decode;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  imem_addr;
    logic        imem_rden;
    logic [31:0] imem_rdata = '0;
    logic        op_valid;
    logic        op_ready = 1'b1;
    logic [5:0]  op_code;
    logic [4:0]  op_rd, op_rs1, op_rs2;
    logic [31:0] op_imm;
    logic [9:0]  op_pc;
    logic        pc_wren = 1'b0;
    logic        pc_add_or_set = 1'b0;
    logic [9:0]  pc_value = '0;

    logic [31:0] imem [1024];
    int vectors = 0;
    int errors = 0;

    // RV32I match patterns in control-unit order (LUI=0 ... AND=36, ECALL=37)
    localparam logic [31:0] MATCH [38] = '{
        32'h00000037, 32'h00000017, 32'h0000006f, 32'h00000067,
        32'h00000063, 32'h00001063, 32'h00004063, 32'h00005063, 32'h00006063, 32'h00007063,
        32'h00000003, 32'h00001003, 32'h00002003, 32'h00004003, 32'h00005003,
        32'h00000023, 32'h00001023, 32'h00002023,
        32'h00000013, 32'h00002013, 32'h00003013, 32'h00004013, 32'h00006013, 32'h00007013,
        32'h00001013, 32'h00005013, 32'h40005013,
        32'h00000033, 32'h40000033, 32'h00001033, 32'h00002033, 32'h00003033,
        32'h00004033, 32'h00005033, 32'h40005033, 32'h00006033, 32'h00007033,
        32'h00000073};

    fetch_decode dut (
        .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_rden(imem_rden),
        .imem_rdata(imem_rdata), .op_valid(op_valid), .op_ready(op_ready),
        .op_code(op_code), .op_rd(op_rd), .op_rs1(op_rs1), .op_rs2(op_rs2),
        .op_imm(op_imm), .op_pc(op_pc), .pc_wren(pc_wren),
        .pc_add_or_set(pc_add_or_set), .pc_value(pc_value));

    always #5 clk = ~clk;

    // registered instruction memory
    always @(posedge clk) if (imem_rden) imem_rdata <= imem[imem_addr];

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mask_of(input int k);
        if (k <= 2) return 32'h0000007f;
        if (k == 37) return 32'hffffffff;
        if (k >= 24 && k != 25 && k != 26 || k == 25 || k == 26) return 32'hfe00707f;
        return 32'h0000707f;
    endfunction

    function automatic int ref_code(input logic [31:0] w);
        for (int k = 0; k < 38; k++) if ((w & mask_of(k)) == MATCH[k]) return k;
        return 63;
    endfunction

    function automatic logic [31:0] ref_imm(input logic [31:0] w, input int c);
        logic [31:0] s;
        s = w[31] ? 32'hffffffff : 32'h0;
        if (c <= 1) return w & 32'hfffff000;
        if (c == 2) return (s << 20) | (((w >> 12) & 255) << 12) | (((w >> 20) & 1) << 11) | (((w >> 21) & 1023) << 1);
        if (c >= 4 && c <= 9) return (s << 12) | (((w >> 7) & 1) << 11) | (((w >> 25) & 63) << 5) | (((w >> 8) & 15) << 1);
        if (c >= 15 && c <= 17) return (s << 12) | (((w >> 25) & 127) << 5) | ((w >> 7) & 31);
        if (c >= 24 && c <= 26) return (w >> 20) & 31;
        if (c >= 27 && c <= 36) return 32'h0;
        return (s << 12) | (w >> 20);
    endfunction

    function automatic logic [31:0] gen_word();
        int k;
        if ($urandom_range(0, 7) == 0) return $urandom;
        k = $urandom_range(0, 37);
        return MATCH[k] | ($urandom & ~mask_of(k));
    endfunction

    task automatic check_dec(input logic [31:0] w);
        int c;
        c = ref_code(w);
        check("code", op_code, c);
        check("rd", op_rd, (w >> 7) & 31);
        check("rs1", op_rs1, (w >> 15) & 31);
        check("rs2", op_rs2, (w >> 20) & 31);
        if (c != 63) check("imm", op_imm, ref_imm(w, c));
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!op_valid && n < 12);
        check("valid_timeout", op_valid, 1);
    endtask

    initial begin
        int n;
        logic [62:0] snap;
        logic [9:0] exp_pc, last_pc;
        logic prev_v;
        int idle;
        for (int i = 0; i < 1024; i++) imem[i] = 32'h0;
        imem[0] = 32'h00500093;
        imem[1] = 32'hfff00113;
        imem[2] = 32'h12345037;
        imem[3] = 32'hffffffff;
        imem[4] = 32'h00000073;
        imem[5] = 32'h00100073;
        imem[10'h3ff] = 32'h00a00093;
        imem[10'h010] = 32'h00000073;
        #2 rst = 1'b0;
        #2;
        check("rst_outs", {op_valid, op_code, op_rd, op_rs1, op_rs2, op_imm, op_pc, imem_rden, imem_addr}, '0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1 check("first_fetch", {imem_rden, imem_addr}, {1'b1, 10'd0});
        wait_valid(n);
        check("latency0", n, 2);
        check("addi_code", op_code, 18);
        check("addi_fields", {op_rd, op_rs1, op_imm, op_pc}, {5'd1, 5'd0, 32'd5, 10'd0});
        @(negedge clk);
        check("next_fetch1", {imem_rden, imem_addr, op_valid}, {1'b1, 10'd1, 1'b0});
        wait_valid(n);
        check("neg_imm", {op_code, op_imm}, {6'd18, 32'hffffffff});
        @(negedge clk);
        op_ready = 1'b0;
        wait_valid(n);
        check("lui", {op_code, op_imm}, {6'd0, 32'h12345000});
        snap = {op_code, op_rd, op_rs1, op_rs2, op_imm, op_pc};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_stable", {op_valid, imem_rden, op_code, op_rd, op_rs1, op_rs2, op_imm, op_pc}, {2'b10, snap});
        end
        op_ready = 1'b1;
        @(negedge clk);
        check("advance", {imem_rden, imem_addr, op_valid}, {1'b1, 10'd3, 1'b0});
        for (int k = 3; k <= 5; k++) begin
            wait_valid(n);
            check("sys_illegal", op_code, (k == 4) ? 37 : 63);
            @(negedge clk);
            check("seq_fetch", imem_addr, k + 1);
        end
        @(negedge clk);
        check("wait_rden", imem_rden, 0);
        pc_wren = 1'b1; pc_add_or_set = 1'b1; pc_value = 10'h3ff;
        @(negedge clk);
        pc_wren = 1'b0;
        check("redir_wait", {op_valid, imem_rden, imem_addr}, {1'b0, 1'b1, 10'h3ff});
        wait_valid(n);
        check("redir_pc", {op_pc, op_code}, {10'h3ff, 6'd18});
        @(negedge clk);
        check("wrap", imem_addr, 0);
        pc_wren = 1'b1; pc_add_or_set = 1'b1; pc_value = 10'h010;
        @(negedge clk);
        pc_wren = 1'b0;
        wait_valid(n);
        check("op_pc_10", op_pc, 10'h010);
        pc_wren = 1'b1; pc_add_or_set = 1'b0; pc_value = 10'h004;
        @(negedge clk);
        pc_wren = 1'b0;
        op_ready = 1'b0;
        check("redir_add", {op_valid, imem_rden, imem_addr}, {1'b0, 1'b1, 10'h014});
        wait_valid(n);
        #2 rst = 1'b0;
        #1 check("async_rst", {op_valid, imem_rden, imem_addr, op_code}, '0);
        for (int i = 0; i < 1024; i++) imem[i] = gen_word();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        op_ready = 1'b1;
        #1 check("rst_release", {op_valid, imem_rden, imem_addr}, {1'b0, 1'b1, 10'd0});
        exp_pc = '0; last_pc = '0; prev_v = 1'b0; idle = 0; snap = '0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            pc_wren = 1'b0;
            if (op_valid && !prev_v) begin
                check("rnd_pc", op_pc, exp_pc);
                check_dec(imem[exp_pc]);
                last_pc = exp_pc;
                snap = {op_code, op_rd, op_rs1, op_rs2, op_imm, op_pc};
                idle = 0;
            end else if (op_valid) begin
                check("rnd_stable", {op_code, op_rd, op_rs1, op_rs2, op_imm, op_pc}, snap);
            end else begin
                idle++;
                check("rnd_latency", idle <= 3, 1);
            end
            if (imem_rden) check("rnd_fetch", imem_addr, exp_pc);
            prev_v = op_valid;
            op_ready = $urandom_range(0, 3) != 0;
            if ($urandom_range(0, 15) == 0) begin
                pc_wren = 1'b1;
                pc_add_or_set = 1'($urandom);
                pc_value = 10'($urandom);
                exp_pc = pc_add_or_set ? pc_value : last_pc + pc_value;
                idle = 0;
                prev_v = 1'b0;
            end else if (op_valid && op_ready) begin
                exp_pc = last_pc + 10'd1;
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
